// File: rtl/cpu_program_loader_if.sv
// Byte-stream and CPU programming-port signals of the program loader.
// The loader connects to the slave modport; the host/CPU side drives the master modport.
interface cpu_program_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       programming;
  logic [7:0] prog_data;
  logic       cpu_ready;
  logic       cpu_done;

  modport master (
    output s_data, s_valid, cpu_ready, cpu_done,
    input  s_ready, programming, prog_data
  );

  modport slave (
    input  s_data, s_valid, cpu_ready, cpu_done,
    output s_ready, programming, prog_data
  );
endinterface

// File: rtl/cpu_program_loader.sv
// Buffers a RAM image from a valid/ready byte stream, then feeds it to the
// 8-bit CPU's programming port, one byte per cpu_ready pulse.
module cpu_program_loader #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_program_loader_if.slave  bus,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [4:0]           byte_count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PROG, DONE, ERROR} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [4:0]    rd_ptr;
  logic [WW-1:0] watchdog;
  logic          ready_q;
  logic          accept;
  logic          fall;
  logic          rise;
  logic [4:0]    count_inc;
  logic [4:0]    rd_nxt;

  always_comb begin
    accept    = (state == IDLE) && bus.s_valid && bus.s_ready;
    count_inc = byte_count + 5'(accept);
    fall      = ready_q && !bus.cpu_ready;
    rise      = !ready_q && bus.cpu_ready;
    rd_nxt    = rd_ptr + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst && accept)
      mem[wr_ptr] <= bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.programming <= 1'b0;
      bus.prog_data   <= '0;
      bus.s_ready     <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      byte_count      <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      watchdog        <= '0;
      ready_q         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wr_ptr     <= wr_ptr + AW'(1);
            byte_count <= count_inc;
          end
          if (start) begin
            state           <= PROG;
            bus.programming <= 1'b1;
            busy            <= 1'b1;
            bus.s_ready     <= 1'b0;
            rd_ptr          <= '0;
            watchdog        <= '0;
            ready_q         <= 1'b0;
            // A byte landing in the start cycle is not yet in mem; forward it.
            if (byte_count != '0)
              bus.prog_data <= mem[0];
            else if (accept)
              bus.prog_data <= bus.s_data;
            else
              bus.prog_data <= '0;
          end else begin
            bus.s_ready <= (count_inc < 5'(DEPTH));
          end
        end

        PROG: begin
          ready_q <= bus.cpu_ready;
          if (bus.cpu_done) begin
            state           <= DONE;
            done            <= 1'b1;
            bus.programming <= 1'b0;
            busy            <= 1'b0;
            bus.prog_data   <= '0;
            byte_count      <= '0;
            wr_ptr          <= '0;
          end else if ((fall && rd_ptr == 5'(DEPTH)) ||
                       (!fall && !rise && watchdog == WW'(TIMEOUT - 1))) begin
            state           <= ERROR;
            error           <= 1'b1;
            bus.programming <= 1'b0;
            busy            <= 1'b0;
            bus.prog_data   <= '0;
          end else if (fall) begin
            rd_ptr        <= rd_nxt;
            watchdog      <= '0;
            bus.prog_data <= (rd_nxt < byte_count) ? mem[rd_nxt[AW-1:0]] : '0;
          end else if (rise) begin
            watchdog <= '0;
          end else begin
            watchdog <= watchdog + WW'(1);
          end
        end

        DONE: begin
          state       <= IDLE;
          bus.s_ready <= 1'b1;
        end

        ERROR: begin
          state <= ERROR;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed + randomized bench for cpu_program_loader against a queue-based image model.
module tb_cpu_program_loader;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [4:0] byte_count;

  cpu_program_loader_if bus();

  int total = 0;
  int bad   = 0;
  logic [7:0] img[$];

  always #5 clk = ~clk;

  cpu_program_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .byte_count (byte_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    return (k < img.size()) ? img[k] : 8'h00;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.cpu_ready = 1'b0; bus.cpu_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    img.delete();
  endtask

  task automatic chk_prog_entry();
    chk("entry_programming", bus.programming, 1);
    chk("entry_busy", busy, 1);
    chk("entry_s_ready", bus.s_ready, 0);
    chk("entry_prog_data", bus.prog_data, exp_byte(0));
    chk("entry_byte_count", byte_count, img.size());
  endtask

  task automatic start_prog();
    start = 1'b1; tick(); start = 1'b0;
    chk_prog_entry();
  endtask

  task automatic push(input logic [7:0] b, input logic with_start);
    int unsigned n = 0;
    bus.s_data = b; bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("push_wait_s_ready", bus.s_ready, 1);
    start = with_start;
    tick();
    bus.s_valid = 1'b0; start = 1'b0;
    img.push_back(b);
    if (with_start) chk_prog_entry();
    else chk("push_byte_count", byte_count, img.size());
  endtask

  task automatic run_cpu(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      int h = (hi > 0) ? hi : int'($urandom_range(1, 4));
      int l = (lo > 0) ? lo : int'($urandom_range(1, 4));
      chk("prog_data", bus.prog_data, exp_byte(k));
      bus.cpu_ready = 1'b1;
      repeat (h) begin
        tick();
        chk("prog_data_stable", bus.prog_data, exp_byte(k));
      end
      bus.cpu_ready = 1'b0;
      repeat (l) tick();
    end
  endtask

  task automatic finish_done();
    bus.cpu_done = 1'b1; tick(); bus.cpu_done = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_error", error, 0);
    chk("done_programming", bus.programming, 0);
    chk("done_busy", busy, 0);
    chk("done_byte_count", byte_count, 0);
    tick();
    chk("done_cleared", done, 0);
    chk("idle_s_ready", bus.s_ready, 1);
    img.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int unsigned n;
    // Reset
    do_reset();
    chk("rst_programming", bus.programming, 0);
    chk("rst_prog_data", bus.prog_data, 8'h00);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_byte_count", byte_count, 0);

    // Partial image with fixed 2/2 CPU pulses
    push(8'hA1, 1'b0); push(8'hB2, 1'b0); push(8'hC3, 1'b0);
    start_prog();
    run_cpu(DEPTH, 2, 2);
    finish_done();

    // Start coincident with the first byte of an empty buffer
    push(8'h5A, 1'b1);
    run_cpu(DEPTH, 0, 0);
    finish_done();

    // Randomized images
    for (int t = 0; t < 4; t++) begin
      int len = int'($urandom_range(0, DEPTH));
      logic same = ($urandom_range(0, 1) == 1) && (len > 0);
      for (int j = 0; j < len; j++) begin
        repeat ($urandom_range(0, 2)) tick();
        push(8'($urandom), same && (j == len - 1));
      end
      if (!same) start_prog();
      run_cpu(DEPTH, 0, 0);
      finish_done();
    end

    // Full buffer: 17 bytes with s_valid held high
    bus.s_valid = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      bus.s_data = 8'(i);
      if (img.size() < DEPTH) img.push_back(8'(i));
      tick();
      chk("full_byte_count", byte_count, img.size());
      chk("full_s_ready", bus.s_ready, img.size() < DEPTH);
    end
    bus.s_valid = 1'b0;
    start_prog();
    run_cpu(DEPTH, 0, 0);
    finish_done();

    // Timeout with cpu_ready held low; later start ignored
    start_prog();
    n = 0;
    while (bus.programming && n < 100) begin tick(); n++; end
    chk("timeout_prog_cycles", n, TIMEOUT);
    chk("timeout_error", error, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_prog_data", bus.prog_data, 8'h00);
    chk("timeout_s_ready", bus.s_ready, 0);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("error_start_ignored", bus.programming, 0);
    chk("error_sticky", error, 1);
    do_reset();
    chk("error_cleared_by_rst", error, 0);

    // cpu_done on the same cycle as the timeout wins
    start_prog();
    repeat (TIMEOUT - 1) tick();
    chk("pre_timeout_programming", bus.programming, 1);
    finish_done();

    // Overrun: one ready pulse beyond DEPTH
    start_prog();
    run_cpu(DEPTH, 0, 0);
    chk("pre_overrun_error", error, 0);
    chk("pre_overrun_programming", bus.programming, 1);
    bus.cpu_ready = 1'b1; tick(); bus.cpu_ready = 1'b0; tick();
    chk("overrun_error", error, 1);
    chk("overrun_programming", bus.programming, 0);
    chk("overrun_busy", busy, 0);
    do_reset();

    // Reset mid-load after five bytes consumed
    for (int j = 0; j < 6; j++) push(8'($urandom), 1'b0);
    start_prog();
    run_cpu(5, 0, 0);
    rst = 1'b1; tick();
    chk("midrst_programming", bus.programming, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_byte_count", byte_count, 0);
    chk("midrst_s_ready", bus.s_ready, 1);
    chk("midrst_prog_data", bus.prog_data, 8'h00);
    rst = 1'b0; img.delete();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
